mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single external memory bus between instruction fetch (IF) and the MEM-stage data port.
- One transaction is outstanding at a time. Each transaction is registered onto the bus and held until the slave acks or a timeout fires.
- Read data and a one-cycle valid pulse go back to the owning requester.
- Stall outputs freeze the owning pipeline stage while its access is pending.

Parameters:
- TIMEOUT, 16: cycles in BUSY without bus_ack_i before the access is aborted (min 2).
- CNT_W, 5: timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- cpu_clk_50M  in  1  clock, all state on rising edge
- cpu_rst_n  in  1  asynchronous active-low reset
- inst_req_i  in  1  IF read request; held until inst_valid_o
- inst_addr_i  in  32  IF read address
- inst_rdata_o  out  32  instruction returned
- inst_valid_o  out  1  one-cycle pulse: inst_rdata_o valid
- inst_stall_o  out  1  inst_req_i & ~inst_valid_o (combinational)
- data_req_i  in  1  MEM request; held until data_valid_o
- data_wen_i  in  1  1 = write, 0 = read
- data_addr_i  in  32  data address
- data_wdata_i  in  32  store data
- data_rdata_o  out  32  load data returned
- data_valid_o  out  1  one-cycle pulse: access complete
- data_stall_o  out  1  data_req_i & ~data_valid_o (combinational)
- bus_req_o  out  1  bus access strobe, registered
- bus_wen_o  out  1  bus write enable, registered
- bus_addr_o  out  32  bus address, registered
- bus_wdata_o  out  32  bus write data, registered
- bus_rdata_i  in  32  bus read data, sampled with bus_ack_i
- bus_ack_i  in  1  slave completion, one cycle
- err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (cpu_rst_n=0, asynchronous): state=IDLE; all registered outputs 0, including rdata regs, valid, bus_*, err_o; counter 0; last-owner = INST.
- States:
  - IDLE: no transaction outstanding.
  - BUSY: bus_req_o=1, one owner latched.
- IDLE eligibility: a requester is eligible if req_i=1 and its valid_o=0 this cycle. The valid mask prevents re-granting a request being retired.
- IDLE arbitration: if any requester is eligible, on the edge:
  - latch owner;
  - bus_addr_o/bus_wen_o/bus_wdata_o take the owner's inputs (inst: wen=0, wdata=0);
  - bus_req_o<=1, counter<=0, state<=BUSY.
  - Grant latency is 1 cycle from request to bus_req_o.
- Priority (default): data wins over inst when both are eligible.
- BUSY with bus_ack_i=1:
  - bus_req_o<=0; owner valid_o<=1 for exactly one cycle; state<=IDLE.
  - Read: owner rdata_o<=bus_rdata_i.
  - Write: data_rdata_o unchanged.
- BUSY with no ack: counter increments. When the counter reaches TIMEOUT-1 with no ack:
  - abort: bus_req_o<=0; owner valid_o<=1; owner rdata_o<=0 for reads; err_o<=1 one cycle; state<=IDLE.
  - An ack in the same cycle takes precedence over timeout.
- Bus outputs hold stable throughout BUSY; requester input changes during BUSY are ignored.
- Minimum transaction:
  - grant edge → ack (earliest next cycle) → valid → next grant possible one cycle later.
  - So 3 cycles per back-to-back access to one port, 2 when alternating ports.
- bus_ack_i in IDLE is ignored.
- rdata_o regs hold their value until the next completion for that port.
- Reset mid-BUSY: transaction dropped, no valid or err pulse; the requester retries after reset.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin. With both eligible, grant goes to the port that was not last-owner; last-owner updates on every grant.
- Undefined: fixed data>inst priority; last-owner register not built.

Test Plan:
- Single load:
  - Stimulus: data_req_i=1, wen=0, addr=0x0000_1000; ack in 2nd BUSY cycle with rdata=0xDEAD_BEEF.
  - Response: bus_req_o high 2 cycles; data_valid_o pulses once; data_rdata_o=0xDEAD_BEEF; data_stall_o low in the valid cycle.
- Store:
  - Stimulus: wen=1, addr=0x0000_2004, wdata=0x1234_5678; ack after 1 cycle.
  - Response: bus_wen_o=1; bus_wdata_o=0x1234_5678 stable until ack; data_rdata_o unchanged.
- Contention:
  - Stimulus: inst_req_i and data_req_i both asserted in the same cycle.
  - Response without MEM_ARB_RR_EN: data granted first, inst next; no valid pulse is ever repeated for one request.
  - Response with MEM_ARB_RR_EN (continuous requests): grants alternate data/inst/data.
- Timeout:
  - Stimulus: TIMEOUT=16, inst read, bus_ack_i held 0.
  - Response: after 16 BUSY cycles, bus_req_o drops; inst_valid_o=1, inst_rdata_o=0, err_o=1, each for one cycle.
- Ack/timeout race:
  - Stimulus: ack arrives exactly in the counter=TIMEOUT-1 cycle.
  - Response: normal completion; err_o stays 0.
- Reset mid-BUSY:
  - Stimulus: cpu_rst_n=0 asynchronously in mid-BUSY.
  - Response: bus_req_o=0 immediately, no valid pulse; after release with data_req_i still high, the request is re-granted.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester, bus and error signal bundle for mem_bus_arbiter
//
// Purpose:
//   Groups the IF port, the MEM data port, the external memory bus and the
//   error pulse of mem_bus_arbiter into one interface.
//
// Modports:
//   master - arbiter view: consumes requests and bus responses, drives
//            completion data, valid/stall, bus strobes and err_o.
//   slave  - environment view: drives requests and bus responses, observes
//            everything the arbiter produces.
//
// Signals:
//   inst_req_i / inst_addr_i                  IF read request and address
//   inst_rdata_o / inst_valid_o / inst_stall_o IF response, pulse, stall
//   data_req_i / data_wen_i / data_addr_i / data_wdata_i  MEM request
//   data_rdata_o / data_valid_o / data_stall_o MEM response, pulse, stall
//   bus_req_o / bus_wen_o / bus_addr_o / bus_wdata_o      registered bus strobes
//   bus_rdata_i / bus_ack_i                   slave response
//   err_o                                     one-cycle timeout abort pulse

interface mem_bus_arbiter_if;
  logic        inst_req_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_rdata_o;
  logic        inst_valid_o;
  logic        inst_stall_o;

  logic        data_req_i;
  logic        data_wen_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        data_valid_o;
  logic        data_stall_o;

  logic        bus_req_o;
  logic        bus_wen_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;

  logic        err_o;

  modport master (
    input  inst_req_i, inst_addr_i,
    output inst_rdata_o, inst_valid_o, inst_stall_o,
    input  data_req_i, data_wen_i, data_addr_i, data_wdata_i,
    output data_rdata_o, data_valid_o, data_stall_o,
    output bus_req_o, bus_wen_o, bus_addr_o, bus_wdata_o,
    input  bus_rdata_i, bus_ack_i,
    output err_o
  );

  modport slave (
    output inst_req_i, inst_addr_i,
    input  inst_rdata_o, inst_valid_o, inst_stall_o,
    output data_req_i, data_wen_i, data_addr_i, data_wdata_i,
    input  data_rdata_o, data_valid_o, data_stall_o,
    input  bus_req_o, bus_wen_o, bus_addr_o, bus_wdata_o,
    output bus_rdata_i, bus_ack_i,
    input  err_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one external memory bus between IF fetch and MEM data port
//
// Purpose:
//   Arbitrates between the instruction-fetch read port and the MEM-stage data
//   port. One transaction is outstanding at a time; it is registered onto the
//   bus and held until bus_ack_i or a timeout abort. Completion returns read
//   data and a one-cycle valid pulse to the owning requester; a timeout abort
//   additionally pulses err_o and returns zero read data.
//
// Parameters:
//   TIMEOUT - BUSY cycles without bus_ack_i before abort (min 2)
//   CNT_W   - timeout counter width, 2**CNT_W > TIMEOUT
//
// Ports:
//   cpu_clk_50M - clock, all state on rising edge
//   cpu_rst_n   - asynchronous active-low reset
//   mbus        - mem_bus_arbiter_if.master (requesters, bus, err_o)
//
// Build option:
//   MEM_ARB_RR_EN - when defined, contention is resolved round-robin using a
//                   last-owner register; otherwise data always beats inst.

module mem_bus_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  mem_bus_arbiter_if.master mbus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state;
  owner_e           owner;
  logic [CNT_W-1:0] cnt;

  logic             bus_req_q;
  logic             bus_wen_q;
  logic [31:0]      bus_addr_q;
  logic [31:0]      bus_wdata_q;

  logic [31:0]      inst_rdata_q;
  logic [31:0]      data_rdata_q;
  logic             inst_valid_q;
  logic             data_valid_q;
  logic             err_q;

  logic             inst_elig;
  logic             data_elig;
  logic             grant_any;
  owner_e           grant_owner;

`ifdef MEM_ARB_RR_EN
  owner_e           last_owner;
`endif

  // A requester whose valid pulse is high this cycle is retiring its request;
  // masking it stops the still-high req from being granted a second time.
  always_comb begin
    inst_elig   = mbus.inst_req_i & ~inst_valid_q;
    data_elig   = mbus.data_req_i & ~data_valid_q;
    grant_any   = inst_elig | data_elig;
    grant_owner = OWN_INST;
`ifdef MEM_ARB_RR_EN
    if (inst_elig && data_elig) begin
      grant_owner = (last_owner == OWN_DATA) ? OWN_INST : OWN_DATA;
    end else if (data_elig) begin
      grant_owner = OWN_DATA;
    end
`else
    if (data_elig) begin
      grant_owner = OWN_DATA;
    end
`endif
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state        <= ST_IDLE;
      owner        <= OWN_INST;
      cnt          <= '0;
      bus_req_q    <= 1'b0;
      bus_wen_q    <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_owner   <= OWN_INST;
`endif
    end else begin
      // Valid and error are single-cycle pulses.
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      err_q        <= 1'b0;

      case (state)
        ST_IDLE: begin
          // bus_ack_i is ignored here: nothing is outstanding.
          if (grant_any) begin
            owner     <= grant_owner;
            state     <= ST_BUSY;
            bus_req_q <= 1'b1;
            cnt       <= '0;
            if (grant_owner == OWN_DATA) begin
              bus_wen_q   <= mbus.data_wen_i;
              bus_addr_q  <= mbus.data_addr_i;
              bus_wdata_q <= mbus.data_wdata_i;
            end else begin
              bus_wen_q   <= 1'b0;
              bus_addr_q  <= mbus.inst_addr_i;
              bus_wdata_q <= '0;
            end
`ifdef MEM_ARB_RR_EN
            last_owner <= grant_owner;
`endif
          end
        end

        ST_BUSY: begin
          // Bus strobes are held; requester inputs are not looked at here.
          // An ack in the final counter cycle wins over the abort.
          if (mbus.bus_ack_i) begin
            bus_req_q <= 1'b0;
            state     <= ST_IDLE;
            if (owner == OWN_DATA) begin
              data_valid_q <= 1'b1;
              if (!bus_wen_q) begin
                data_rdata_q <= mbus.bus_rdata_i;
              end
            end else begin
              inst_valid_q <= 1'b1;
              inst_rdata_q <= mbus.bus_rdata_i;
            end
          end else if (cnt == CNT_LAST) begin
            bus_req_q <= 1'b0;
            state     <= ST_IDLE;
            err_q     <= 1'b1;
            if (owner == OWN_DATA) begin
              data_valid_q <= 1'b1;
              if (!bus_wen_q) begin
                data_rdata_q <= '0;
              end
            end else begin
              inst_valid_q <= 1'b1;
              inst_rdata_q <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mbus.inst_rdata_o = inst_rdata_q;
  assign mbus.inst_valid_o = inst_valid_q;
  assign mbus.inst_stall_o = mbus.inst_req_i & ~inst_valid_q;

  assign mbus.data_rdata_o = data_rdata_q;
  assign mbus.data_valid_o = data_valid_q;
  assign mbus.data_stall_o = mbus.data_req_i & ~data_valid_q;

  assign mbus.bus_req_o    = bus_req_q;
  assign mbus.bus_wen_o    = bus_wen_q;
  assign mbus.bus_addr_o   = bus_addr_q;
  assign mbus.bus_wdata_o  = bus_wdata_q;

  assign mbus.err_o        = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter

module tb_mem_bus_arbiter;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic        first_is_data;
  logic [31:0] first_addr;
  logic [31:0] second_addr;

  mem_bus_arbiter_if mbi ();

  mem_bus_arbiter #(
    .TIMEOUT(16),
    .CNT_W  (5)
  ) dut (
    .cpu_clk_50M(clk),
    .cpu_rst_n  (rst_n),
    .mbus       (mbi)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    mbi.inst_req_i   = 1'b0;
    mbi.inst_addr_i  = '0;
    mbi.data_req_i   = 1'b0;
    mbi.data_wen_i   = 1'b0;
    mbi.data_addr_i  = '0;
    mbi.data_wdata_i = '0;
    mbi.bus_rdata_i  = '0;
    mbi.bus_ack_i    = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_bus_req", 32'(mbi.bus_req_o), 32'd0);
    check("rst_bus_addr", mbi.bus_addr_o, 32'd0);
    check("rst_bus_wdata", mbi.bus_wdata_o, 32'd0);
    check("rst_data_valid", 32'(mbi.data_valid_o), 32'd0);
    check("rst_inst_rdata", mbi.inst_rdata_o, 32'd0);
    check("rst_err", 32'(mbi.err_o), 32'd0);
    rst_n = 1'b1;

    // Ack while idle is ignored
    mbi.bus_ack_i   = 1'b1;
    mbi.bus_rdata_i = 32'h5555_5555;
    tick();
    check("idle_ack_valid", 32'({mbi.inst_valid_o, mbi.data_valid_o}), 32'd0);
    check("idle_ack_rdata", mbi.data_rdata_o, 32'd0);
    mbi.bus_ack_i = 1'b0;

    // Single load, ack in second BUSY cycle
    mbi.data_req_i  = 1'b1;
    mbi.data_wen_i  = 1'b0;
    mbi.data_addr_i = 32'h0000_1000;
    #1;
    check("ld_stall_req", 32'(mbi.data_stall_o), 32'd1);
    tick();
    check("ld_bus_req1", 32'(mbi.bus_req_o), 32'd1);
    check("ld_bus_addr", mbi.bus_addr_o, 32'h0000_1000);
    check("ld_bus_wen", 32'(mbi.bus_wen_o), 32'd0);
    tick();
    check("ld_bus_req2", 32'(mbi.bus_req_o), 32'd1);
    check("ld_valid_early", 32'(mbi.data_valid_o), 32'd0);
    mbi.bus_ack_i   = 1'b1;
    mbi.bus_rdata_i = 32'hDEAD_BEEF;
    tick();
    check("ld_bus_req_drop", 32'(mbi.bus_req_o), 32'd0);
    check("ld_valid", 32'(mbi.data_valid_o), 32'd1);
    check("ld_rdata", mbi.data_rdata_o, 32'hDEAD_BEEF);
    check("ld_stall_valid", 32'(mbi.data_stall_o), 32'd0);
    check("ld_err", 32'(mbi.err_o), 32'd0);
    mbi.data_req_i = 1'b0;
    mbi.bus_ack_i  = 1'b0;
    tick();
    check("ld_valid_once", 32'(mbi.data_valid_o), 32'd0);

    // Store, ack after one cycle; input change during BUSY ignored
    mbi.data_req_i   = 1'b1;
    mbi.data_wen_i   = 1'b1;
    mbi.data_addr_i  = 32'h0000_2004;
    mbi.data_wdata_i = 32'h1234_5678;
    tick();
    check("st_bus_wen", 32'(mbi.bus_wen_o), 32'd1);
    check("st_bus_addr", mbi.bus_addr_o, 32'h0000_2004);
    check("st_bus_wdata", mbi.bus_wdata_o, 32'h1234_5678);
    mbi.data_wdata_i = 32'hFFFF_0000;
    mbi.data_addr_i  = 32'h0000_9999;
    mbi.bus_ack_i    = 1'b1;
    mbi.bus_rdata_i  = 32'h0BAD_0BAD;
    tick();
    check("st_valid", 32'(mbi.data_valid_o), 32'd1);
    check("st_rdata_kept", mbi.data_rdata_o, 32'hDEAD_BEEF);
    check("st_wdata_held", mbi.bus_wdata_o, 32'h1234_5678);
    check("st_addr_held", mbi.bus_addr_o, 32'h0000_2004);
    mbi.data_req_i = 1'b0;
    mbi.data_wen_i = 1'b0;
    mbi.bus_ack_i  = 1'b0;
    tick();

    // Contention: fixed priority gives data first; round-robin follows the
    // last grant (data above), so inst goes first there.
`ifdef MEM_ARB_RR_EN
    first_is_data = 1'b0;
`else
    first_is_data = 1'b1;
`endif
    first_addr  = first_is_data ? 32'h0000_3000 : 32'h0000_0100;
    second_addr = first_is_data ? 32'h0000_0100 : 32'h0000_3000;
    mbi.inst_req_i  = 1'b1;
    mbi.inst_addr_i = 32'h0000_0100;
    mbi.data_req_i  = 1'b1;
    mbi.data_addr_i = 32'h0000_3000;
    tick();
    check("ct_first_addr", mbi.bus_addr_o, first_addr);
    mbi.bus_ack_i   = 1'b1;
    mbi.bus_rdata_i = 32'hAAAA_0001;
    tick();
    check("ct_first_valid", 32'({mbi.data_valid_o, mbi.inst_valid_o}),
          first_is_data ? 32'd2 : 32'd1);
    check("ct_first_rdata", first_is_data ? mbi.data_rdata_o : mbi.inst_rdata_o,
          32'hAAAA_0001);
    if (first_is_data) mbi.data_req_i = 1'b0;
    else               mbi.inst_req_i = 1'b0;
    mbi.bus_ack_i = 1'b0;
    tick();
    check("ct_second_req", 32'(mbi.bus_req_o), 32'd1);
    check("ct_second_addr", mbi.bus_addr_o, second_addr);
    check("ct_no_repeat", 32'({mbi.data_valid_o, mbi.inst_valid_o}), 32'd0);
    mbi.bus_ack_i   = 1'b1;
    mbi.bus_rdata_i = 32'hBBBB_0002;
    tick();
    check("ct_second_valid", 32'({mbi.data_valid_o, mbi.inst_valid_o}),
          first_is_data ? 32'd1 : 32'd2);
    check("ct_second_rdata", first_is_data ? mbi.inst_rdata_o : mbi.data_rdata_o,
          32'hBBBB_0002);
    mbi.inst_req_i = 1'b0;
    mbi.data_req_i = 1'b0;
    mbi.bus_ack_i  = 1'b0;
    tick();
    check("ct_idle_after", 32'({mbi.bus_req_o, mbi.data_valid_o, mbi.inst_valid_o}), 32'd0);

    // Timeout: inst read, no ack for 16 BUSY cycles
    mbi.inst_req_i  = 1'b1;
    mbi.inst_addr_i = 32'h0000_0400;
    tick();
    check("to_grant", 32'(mbi.bus_req_o), 32'd1);
    mbi.inst_addr_i = 32'h0000_0444;
    for (int i = 1; i < 16; i++) begin
      tick();
      check("to_busy_hold", 32'({mbi.bus_req_o, mbi.inst_valid_o, mbi.err_o}), 32'd4);
    end
    check("to_addr_held", mbi.bus_addr_o, 32'h0000_0400);
    tick();
    check("to_bus_req_drop", 32'(mbi.bus_req_o), 32'd0);
    check("to_inst_valid", 32'(mbi.inst_valid_o), 32'd1);
    check("to_inst_rdata", mbi.inst_rdata_o, 32'd0);
    check("to_err", 32'(mbi.err_o), 32'd1);
    mbi.inst_req_i = 1'b0;
    tick();
    check("to_pulse_end", 32'({mbi.inst_valid_o, mbi.err_o}), 32'd0);

    // Ack exactly in the counter == TIMEOUT-1 cycle
    mbi.data_req_i  = 1'b1;
    mbi.data_wen_i  = 1'b0;
    mbi.data_addr_i = 32'h0000_5000;
    tick();
    for (int i = 1; i < 16; i++) tick();
    check("race_still_busy", 32'(mbi.bus_req_o), 32'd1);
    mbi.bus_ack_i   = 1'b1;
    mbi.bus_rdata_i = 32'hCAFE_F00D;
    tick();
    check("race_valid", 32'(mbi.data_valid_o), 32'd1);
    check("race_no_err", 32'(mbi.err_o), 32'd0);
    check("race_rdata", mbi.data_rdata_o, 32'hCAFE_F00D);
    mbi.data_req_i = 1'b0;
    mbi.bus_ack_i  = 1'b0;
    tick();

    // Asynchronous reset in the middle of BUSY
    mbi.data_req_i  = 1'b1;
    mbi.data_addr_i = 32'h0000_6000;
    tick();
    tick();
    check("rb_busy", 32'(mbi.bus_req_o), 32'd1);
    #5;
    rst_n = 1'b0;
    #1;
    check("rb_req_async", 32'(mbi.bus_req_o), 32'd0);
    check("rb_no_pulse", 32'({mbi.data_valid_o, mbi.err_o}), 32'd0);
    tick();
    check("rb_hold", 32'({mbi.bus_req_o, mbi.data_valid_o, mbi.err_o}), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rb_regrant", 32'(mbi.bus_req_o), 32'd1);
    check("rb_regrant_addr", mbi.bus_addr_o, 32'h0000_6000);
    mbi.bus_ack_i   = 1'b1;
    mbi.bus_rdata_i = 32'h7777_0006;
    tick();
    check("rb_done_valid", 32'(mbi.data_valid_o), 32'd1);
    check("rb_done_rdata", mbi.data_rdata_o, 32'h7777_0006);
    mbi.data_req_i = 1'b0;
    mbi.bus_ack_i  = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
